mem_access_unit: RTL and testbench

- Parametrised successor to the MEM-stage dcache bridge. It sits between the EX/MEM pipeline register and the dcache.
- Adds RV32 sub-word access: LB/LH/LW/LBU/LHU and SB/SH/SW, with byte enables, lane steering and sign/zero extension.
- Runs a multi-cycle request/ready/rvalid handshake with the dcache and stalls the pipeline while the access is in flight.
- Reports misaligned, illegal and timed-out accesses instead of issuing them.

---
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Dcache-side request/ready/rvalid bus of the MEM-stage access unit.
// The unit drives the request side (master); the dcache drives ready/rvalid/rdata (slave).
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  dcache_req;
  logic                  dcache_we;
  logic [ADDR_WIDTH-1:0] dcache_addr;
  logic [31:0]           dcache_wdata;
  logic [3:0]            dcache_byte_en;
  logic                  dcache_ready;
  logic                  dcache_rvalid;
  logic [31:0]           dcache_rdata;

  modport master (
    output dcache_req, dcache_we, dcache_addr, dcache_wdata, dcache_byte_en,
    input  dcache_ready, dcache_rvalid, dcache_rdata
  );

  modport slave (
    input  dcache_req, dcache_we, dcache_addr, dcache_wdata, dcache_byte_en,
    output dcache_ready, dcache_rvalid, dcache_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage bridge between EX/MEM and the dcache: RV32 sub-word loads/stores,
// multi-cycle req/ready/rvalid handshake, pipeline stall, fault reporting.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_valid,
  input  logic              ex_mem_mem_read,
  input  logic              ex_mem_mem_write,
  input  logic [2:0]        ex_mem_funct3,
  input  logic [31:0]       ex_mem_alu_result,
  input  logic [31:0]       ex_mem_mem_write_data,
  output logic [31:0]       mem_read_data,
  output logic              mem_stall,
  output logic              mem_done,
  output logic              mem_fault,
  output logic [1:0]        mem_fault_cause,
  mem_access_unit_if.master dcache
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value seen in the last REQ/WAIT cycle allowed before a bus fault.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  store_q, store_d;
  logic [1:0]            cause_q, cause_d;
  logic [31:0]           rdata_q, rdata_d;

  logic        access;
  logic        illegal_in;
  logic        misalign_in;
  logic        in_req;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;

  generate
    if (ADDR_WIDTH < 32) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^ex_mem_alu_result[31:ADDR_WIDTH];
    end
  endgenerate

  assign access = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);

  always_comb begin
    illegal_in  = ex_mem_mem_write ? !(ex_mem_funct3 inside {3'b000, 3'b001, 3'b010})
                                   : !(ex_mem_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misalign_in = ((ex_mem_funct3[1:0] == 2'b01) && ex_mem_alu_result[0]) ||
                  ((ex_mem_funct3[1:0] == 2'b10) && (ex_mem_alu_result[1:0] != 2'b00));
  end

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = dcache.dcache_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = dcache.dcache_rdata[{addr_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b100:  load_ext = {24'h000000, load_byte};
      3'b101:  load_ext = {16'h0000, load_half};
      default: load_ext = dcache.dcache_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    store_d  = store_q;
    cause_d  = cause_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          addr_d   = ex_mem_alu_result[ADDR_WIDTH-1:0];
          wdata_d  = ex_mem_mem_write_data;
          funct3_d = ex_mem_funct3;
          store_d  = ex_mem_mem_write;
          cnt_d    = '0;
          if (illegal_in) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = S_DONE;
          end else if (misalign_in) begin
            cause_d = CAUSE_MISALIGN;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (dcache.dcache_ready) begin
          state_d = store_q ? S_DONE : S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_DONE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dcache.dcache_rvalid) begin
          rdata_d = load_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_DONE;
        end
      end
      default: begin
        cause_d = CAUSE_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      cause_q  <= CAUSE_NONE;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      store_q  <= store_d;
      cause_q  <= cause_d;
      rdata_q  <= rdata_d;
    end
  end

  // Reset masks the combinational outputs so a request is withdrawn in the reset cycle itself.
  assign in_req = (state_q == S_REQ) && !rst;

  assign dcache.dcache_req     = in_req;
  assign dcache.dcache_we      = in_req && store_q;
  assign dcache.dcache_addr    = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dcache.dcache_wdata   = (in_req && store_q) ? lane_wdata : 32'h0;
  assign dcache.dcache_byte_en = (in_req && store_q) ? lane_be : 4'b0000;

  assign mem_stall       = !rst && (((state_q == S_IDLE) && access) ||
                                    (state_q == S_REQ) || (state_q == S_WAIT));
  assign mem_done        = !rst && (state_q == S_DONE);
  assign mem_fault       = mem_done && (cause_q != CAUSE_NONE);
  assign mem_fault_cause = mem_done ? cause_q : CAUSE_NONE;
  assign mem_read_data   = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised and directed bench for mem_access_unit against a cycle-count level reference model.
module tb_mem_access_unit;

  localparam int TB_T = 8;

  typedef struct packed {
    logic [5:0]  done_cyc;
    logic [5:0]  stall_cnt;
    logic [5:0]  req_cnt;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] rdata;
    logic [11:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        ex_mem_valid;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_mem_write_data;
  logic [31:0] mem_read_data;
  logic        mem_stall;
  logic        mem_done;
  logic        mem_fault;
  logic [1:0]  mem_fault_cause;

  int          total;
  int          passed;
  logic [31:0] prev_rd;

  mem_access_unit_if #(.ADDR_WIDTH(12)) bus ();

  mem_access_unit #(.ADDR_WIDTH(12), .TIMEOUT_CYCLES(TB_T)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .ex_mem_valid          (ex_mem_valid),
    .ex_mem_mem_read       (ex_mem_mem_read),
    .ex_mem_mem_write      (ex_mem_mem_write),
    .ex_mem_funct3         (ex_mem_funct3),
    .ex_mem_alu_result     (ex_mem_alu_result),
    .ex_mem_mem_write_data (ex_mem_mem_write_data),
    .mem_read_data         (mem_read_data),
    .mem_stall             (mem_stall),
    .mem_done              (mem_done),
    .mem_fault             (mem_fault),
    .mem_fault_cause       (mem_fault_cause),
    .dcache                (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected bus-level outcome: store completes one cycle after ready is seen, a load one
  // cycle after rvalid; the access has TB_T-1 cycles of REQ+WAIT before it is faulted.
  function automatic obs_t model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int rw, input int vw,
                                 input logic [31:0] rdata, input logic [31:0] prev);
    obs_t e;
    logic legal, mis;
    logic [1:0] sz;
    logic [7:0] b;
    logic [15:0] h;
    int need;
    e = '0;
    e.rdata = prev;
    sz = f3[1:0];
    legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = ((sz == 2'd1) && a[0]) || ((sz == 2'd2) && (a[1:0] != 2'b00));
    if (!legal || mis) begin
      e.done_cyc = 6'd1;
      e.stall_cnt = 6'd1;
      e.fault = 1'b1;
      e.cause = !legal ? 2'b11 : 2'b01;
      return e;
    end
    e.addr = {a[11:2], 2'b00};
    e.we = wr;
    if (wr) begin
      case (sz)
        2'd0: begin e.be = 4'b0001 << a[1:0]; e.wdata = {4{wd[7:0]}}; end
        2'd1: begin e.be = a[1] ? 4'b1100 : 4'b0011; e.wdata = {2{wd[15:0]}}; end
        default: begin e.be = 4'b1111; e.wdata = wd; end
      endcase
    end
    need = wr ? rw + 1 : rw + vw + 2;
    if (need <= TB_T - 1) begin
      e.done_cyc = 6'(need + 1);
      e.req_cnt = 6'(rw + 1);
      if (!wr) begin
        b = 8'(rdata >> (8 * a[1:0]));
        h = 16'(rdata >> (16 * a[1]));
        case (f3)
          3'd0: e.rdata = {{24{b[7]}}, b};
          3'd1: e.rdata = {{16{h[15]}}, h};
          3'd4: e.rdata = {24'h0, b};
          3'd5: e.rdata = {16'h0, h};
          default: e.rdata = rdata;
        endcase
      end
    end else begin
      e.done_cyc = 6'(TB_T);
      e.req_cnt = 6'((rw + 1 < TB_T - 1) ? rw + 1 : TB_T - 1);
      e.fault = 1'b1;
      e.cause = 2'b10;
    end
    e.stall_cnt = e.done_cyc;
    return e;
  endfunction

  // Drives one access and plays the dcache: ready after rw request cycles, rvalid rw..vw later.
  // Called and returns at 1 time unit after a rising edge.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int rw,
                           input int vw, input logic [31:0] rdata, output obs_t o,
                           output bit hung);
    int req_seen;
    int wait_seen;
    bit accepted;
    o = '0;
    hung = 1'b1;
    req_seen = 0;
    wait_seen = 0;
    accepted = 1'b0;
    ex_mem_valid = 1'b1;
    ex_mem_mem_read = rd;
    ex_mem_mem_write = wr;
    ex_mem_funct3 = f3;
    ex_mem_alu_result = a;
    ex_mem_mem_write_data = wd;
    bus.dcache_rdata = rdata;
    for (int k = 0; k < 30; k++) begin
      bus.dcache_ready = 1'b0;
      bus.dcache_rvalid = 1'b0;
      if (bus.dcache_req) begin
        if (req_seen == 0) begin
          o.addr = bus.dcache_addr;
          o.we = bus.dcache_we;
          o.be = bus.dcache_byte_en;
          if (wr) o.wdata = bus.dcache_wdata;
        end
        if (req_seen == rw) begin
          bus.dcache_ready = 1'b1;
          accepted = 1'b1;
        end
        req_seen++;
        o.req_cnt = o.req_cnt + 6'd1;
      end else if (accepted && !wr) begin
        if (wait_seen == vw) bus.dcache_rvalid = 1'b1;
        wait_seen++;
      end
      #3;
      if (mem_stall) o.stall_cnt = o.stall_cnt + 6'd1;
      if (mem_done) begin
        o.done_cyc = 6'(k);
        o.fault = mem_fault;
        o.cause = mem_fault_cause;
        o.rdata = mem_read_data;
        hung = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!hung) break;
    end
    ex_mem_valid = 1'b0;
    ex_mem_mem_read = 1'b0;
    ex_mem_mem_write = 1'b0;
    bus.dcache_ready = 1'b0;
    bus.dcache_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #4;
    total++;
    if ({mem_read_data, mem_stall, mem_done, mem_fault, mem_fault_cause, bus.dcache_req,
         bus.dcache_we, bus.dcache_addr, bus.dcache_wdata, bus.dcache_byte_en} !== '0)
      $display("FAIL reset_outputs: got rd=%h stall=%b done=%b req=%b cause=%b, expected all zero",
               mem_read_data, mem_stall, mem_done, bus.dcache_req, mem_fault_cause);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #3;
    total++;
    if ({mem_stall, mem_done, bus.dcache_req, mem_read_data} !== '0)
      $display("FAIL after_reset_idle: got stall=%b done=%b req=%b rd=%h, expected zeros",
               mem_stall, mem_done, bus.dcache_req, mem_read_data);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_idle();
    logic [2:0] pat [4] = '{3'b100, 3'b010, 3'b001, 3'b011};
    for (int i = 0; i < 4; i++) begin
      {ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write} = pat[i];
      #3;
      total++;
      if ({mem_stall, mem_done, bus.dcache_req} !== 3'b000)
        $display("FAIL idle_no_access[%0d]: got stall/done/req=%b, expected 000", i,
                 {mem_stall, mem_done, bus.dcache_req});
      else passed++;
      @(posedge clk);
      #1;
    end
    {ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write} = 3'b000;
  endtask

  task automatic test_store_directed();
    obs_t o, e;
    bit h;
    e = model(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0, prev_rd);
    do_access(1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0, o, h);
    total++;
    if (h || o !== e) $display("FAIL sw_104: got %h expected %h", o, e);
    else passed++;
    total++;
    if ({o.addr, o.be, o.we, o.done_cyc, o.stall_cnt} !== {12'h104, 4'b1111, 1'b1, 6'd2, 6'd2})
      $display("FAIL sw_104_plan: got addr=%h be=%b we=%b done=%0d, expected 104/1111/1/2",
               o.addr, o.be, o.we, o.done_cyc);
    else passed++;
    prev_rd = e.rdata;
    e = model(1'b1, 3'b000, 32'h0A3, 32'h12345678, 1, 0, 32'h0, prev_rd);
    do_access(1'b0, 1'b1, 3'b000, 32'h0A3, 32'h12345678, 1, 0, 32'h0, o, h);
    total++;
    if (h || {o.be, o.wdata, o.addr} !== {4'b1000, 32'h78787878, 12'h0A0} || o !== e)
      $display("FAIL sb_0a3: got be=%b wdata=%h addr=%h obs=%h expected 1000/78787878/0a0",
               o.be, o.wdata, o.addr, o);
    else passed++;
    prev_rd = e.rdata;
  endtask

  task automatic test_load_sign();
    obs_t o, e;
    bit h;
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] adr [4] = '{32'h201, 32'h201, 32'h102, 32'h102};
    logic [31:0] rds [4] = '{32'h00008000, 32'h00008000, 32'h80010000, 32'h80010000};
    logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    for (int i = 0; i < 4; i++) begin
      e = model(1'b0, f3s[i], adr[i], 32'h0, 0, 0, rds[i], prev_rd);
      do_access(1'b1, 1'b0, f3s[i], adr[i], 32'h0, 0, 0, rds[i], o, h);
      total++;
      if (h || o.rdata !== want[i] || o.done_cyc !== 6'd3 || o.fault !== 1'b0 || o !== e)
        $display("FAIL load_ext[%0d]: got rd=%h done=%0d fault=%b, expected %h/3/0",
                 i, o.rdata, o.done_cyc, o.fault, want[i]);
      else passed++;
      prev_rd = e.rdata;
    end
  endtask

  task automatic test_faults();
    obs_t o, e;
    bit h;
    logic        rds [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        wrs [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  f3s [5] = '{3'b010, 3'b011, 3'b100, 3'b001, 3'b110};
    logic [31:0] adr [5] = '{32'h102, 32'h100, 32'h100, 32'h0F1, 32'h103};
    logic [1:0]  cz  [5] = '{2'b01, 2'b11, 2'b11, 2'b01, 2'b11};
    for (int i = 0; i < 5; i++) begin
      e = model(wrs[i], f3s[i], adr[i], 32'h55AA55AA, 0, 0, 32'h0, prev_rd);
      do_access(rds[i], wrs[i], f3s[i], adr[i], 32'h55AA55AA, 0, 0, 32'h0, o, h);
      total++;
      if (h || o.cause !== cz[i] || o.fault !== 1'b1 || o.done_cyc !== 6'd1 ||
          o.req_cnt !== 6'd0 || o !== e)
        $display("FAIL fault[%0d]: got cause=%b fault=%b done=%0d req=%0d, expected %b/1/1/0",
                 i, o.cause, o.fault, o.done_cyc, o.req_cnt, cz[i]);
      else passed++;
      prev_rd = e.rdata;
    end
    e = model(1'b1, 3'b010, 32'h40, 32'hA5A5F00F, 2, 0, 32'h0, prev_rd);
    do_access(1'b1, 1'b1, 3'b010, 32'h40, 32'hA5A5F00F, 2, 0, 32'h0, o, h);
    total++;
    if (h || o.we !== 1'b1 || o !== e)
      $display("FAIL read_and_write_is_store: got %h expected %h", o, e);
    else passed++;
    prev_rd = e.rdata;
  endtask

  task automatic test_timeout();
    obs_t o, e;
    bit h;
    e = model(1'b0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hCAFEF00D, prev_rd);
    do_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hCAFEF00D, o, h);
    total++;
    if (h || o !== e) $display("FAIL lw_prime: got %h expected %h", o, e);
    else passed++;
    prev_rd = e.rdata;
    e = model(1'b0, 3'b010, 32'h14, 32'h0, 40, 0, 32'h11111111, prev_rd);
    do_access(1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 40, 0, 32'h11111111, o, h);
    total++;
    if (h || o.req_cnt !== 6'd7 || o.cause !== 2'b10 || o.rdata !== 32'hCAFEF00D || o !== e)
      $display("FAIL timeout_ready: got req=%0d cause=%b rd=%h, expected 7/10/cafef00d",
               o.req_cnt, o.cause, o.rdata);
    else passed++;
    prev_rd = e.rdata;
    e = model(1'b0, 3'b000, 32'h18, 32'h0, 1, 9, 32'h22222222, prev_rd);
    do_access(1'b1, 1'b0, 3'b000, 32'h18, 32'h0, 1, 9, 32'h22222222, o, h);
    total++;
    if (h || o !== e) $display("FAIL timeout_rvalid: got %h expected %h", o, e);
    else passed++;
    prev_rd = e.rdata;
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    bit h;
    ex_mem_valid = 1'b1;
    ex_mem_mem_read = 1'b1;
    ex_mem_mem_write = 1'b0;
    ex_mem_funct3 = 3'b010;
    ex_mem_alu_result = 32'h300;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ex_mem_valid = 1'b0;
    ex_mem_mem_read = 1'b0;
    #3;
    total++;
    if (bus.dcache_req !== 1'b0) $display("FAIL rst_in_req_drop: got req=%b, expected 0", bus.dcache_req);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ex_mem_valid = 1'b1;
    ex_mem_mem_read = 1'b1;
    ex_mem_alu_result = 32'h304;
    @(posedge clk);
    #1;
    bus.dcache_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.dcache_ready = 1'b0;
    rst = 1'b1;
    ex_mem_valid = 1'b0;
    ex_mem_mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.dcache_rvalid = 1'b1;
    bus.dcache_rdata = 32'hAAAA5555;
    #3;
    total++;
    if ({mem_read_data, mem_stall, mem_done, mem_fault, mem_fault_cause, bus.dcache_req,
         bus.dcache_we, bus.dcache_byte_en} !== '0)
      $display("FAIL rst_in_wait_outputs: got rd=%h stall=%b done=%b req=%b, expected zeros",
               mem_read_data, mem_stall, mem_done, bus.dcache_req);
    else passed++;
    @(posedge clk);
    #1;
    bus.dcache_rvalid = 1'b0;
    #3;
    total++;
    if ({mem_read_data, mem_done} !== 33'h0)
      $display("FAIL late_rvalid_ignored: got rd=%h done=%b, expected 0/0", mem_read_data, mem_done);
    else passed++;
    @(posedge clk);
    #1;
    prev_rd = 32'h0;
    e = model(1'b0, 3'b010, 32'h308, 32'h0, 1, 1, 32'h13579BDF, prev_rd);
    do_access(1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 1, 1, 32'h13579BDF, o, h);
    total++;
    if (h || o !== e) $display("FAIL load_after_reset: got %h expected %h", o, e);
    else passed++;
    prev_rd = e.rdata;
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    bit h;
    logic [31:0] a;
    for (int i = 0; i < 6; i++) begin
      a = {20'h0, 10'($urandom), 2'b00};
      if (i[0] == 1'b0) begin
        e = model(1'b1, 3'b010, a, 32'h1000 + i, 0, 0, 32'h0, prev_rd);
        do_access(1'b0, 1'b1, 3'b010, a, 32'h1000 + i, 0, 0, 32'h0, o, h);
      end else begin
        e = model(1'b0, 3'b101, a + 2, 32'h0, 0, 0, 32'hFEDC0000 + i, prev_rd);
        do_access(1'b1, 1'b0, 3'b101, a + 2, 32'h0, 0, 0, 32'hFEDC0000 + i, o, h);
      end
      total++;
      if (h || o !== e) $display("FAIL back_to_back[%0d]: got %h expected %h", i, o, e);
      else passed++;
      prev_rd = e.rdata;
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    bit h;
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a, wd, rdat;
    int rw, vw, kind;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      wd = $urandom;
      rdat = $urandom;
      rw = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) rw = 9;
      vw = $urandom_range(0, 3);
      e = model(wr, f3, a, wd, rw, vw, rdat, prev_rd);
      do_access(rd, wr, f3, a, wd, rw, vw, rdat, o, h);
      total++;
      if (h || o !== e)
        $display("FAIL random[%0d] rd=%b wr=%b f3=%b a=%h rw=%0d vw=%0d: got %h expected %h",
                 i, rd, wr, f3, a, rw, vw, o, e);
      else passed++;
      prev_rd = e.rdata;
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    prev_rd = 32'h0;
    rst = 1'b1;
    ex_mem_valid = 1'b0;
    ex_mem_mem_read = 1'b0;
    ex_mem_mem_write = 1'b0;
    ex_mem_funct3 = 3'b000;
    ex_mem_alu_result = 32'h0;
    ex_mem_mem_write_data = 32'h0;
    bus.dcache_ready = 1'b0;
    bus.dcache_rvalid = 1'b0;
    bus.dcache_rdata = 32'h0;
    test_reset();
    test_idle();
    test_store_directed();
    test_load_sign();
    test_faults();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
